scan_chain_tx: RTL



---
 rtl/scan_pkg.sv | 29 ++
 rtl/scan_chain_tx_tick.sv | 34 +++
 rtl/scan_chain_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan transmit path.
// State encoding, counter sizing and bit-order selection.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 4;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_PW = cnt_w(DEF_DIV);
  localparam int DEF_BW = cnt_w(DEF_WIDTH);

  function automatic logic pick_bit(
    input logic msb_first,
    input logic msb,
    input logic lsb
  );
    return msb_first ? msb : lsb;
  endfunction

endpackage

// File: rtl/scan_chain_tx_tick.sv
// Scan bit-period phase counter.
// Runs 0..DIV-1 while enabled and wraps back to 0 on the tick.
module scan_tick_gen
  import scan_pkg::*;
#(
  parameter int DIV = 4,
  parameter int PW  = cnt_w(DIV)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_en,
  output logic [PW-1:0] o_phase,
  output logic          o_half,
  output logic          o_tick
);

  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] HALF = PW'(DIV / 2);

  logic [PW-1:0] r_phase;

  assign o_phase = r_phase;
  assign o_tick  = (r_phase == LAST);
  assign o_half  = (r_phase >= HALF);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase <= '0;
    end else if (i_en) begin
      r_phase <= o_tick ? '0 : r_phase + 1'b1;
    end
  end

endmodule

// File: rtl/scan_chain_tx.sv
// Serial scan transmitter: shifts a word out on clk/en/data,
// then closes the frame with a DIV-cycle active-low load strobe.
module scan_chain_tx
  import scan_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             scan_clk_out,
  output logic             scan_en_out,
  output logic             scan_data_out,
  output logic             load_n_out,
  output logic             busy_out
);

  localparam int PW = cnt_w(DIV);
  localparam int BW = cnt_w(WIDTH);

  localparam logic [PW-1:0] MID  = PW'(DIV / 2 - 1);
  localparam logic [BW-1:0] LBIT = BW'(WIDTH - 1);
  localparam logic          MSBF = (MSB_FIRST != 0);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sh, w_sh_nxt, w_sh_adv;
  logic [BW-1:0]    r_bit, w_bit_nxt;
  logic             r_sclk, w_sclk_nxt;
  logic             r_sen, w_sen_nxt;
  logic             r_sdat, w_sdat_nxt;
  logic             r_ldn, w_ldn_nxt;

  logic [PW-1:0]    w_phase;
  logic             w_half;
  logic             w_tick;

  scan_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .rstn    (rstn),
    .i_en    (r_state != IDLE),
    .o_phase (w_phase),
    .o_half  (w_half),
    .o_tick  (w_tick)
  );

  assign w_sh_adv = MSBF ? (r_sh << 1) : (r_sh >> 1);

  // Outputs are registered from next-state values so each one
  // lines up with the state/phase it belongs to.
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_bit_nxt   = r_bit;
    w_sclk_nxt  = 1'b0;
    w_sen_nxt   = 1'b0;
    w_sdat_nxt  = 1'b0;
    w_ldn_nxt   = 1'b1;
    unique case (1'b1)
      (r_state == IDLE): begin
        if (valid_in) begin
          w_state_nxt = SHIFT;
          w_sh_nxt    = data_in;
          w_bit_nxt   = '0;
          w_sen_nxt   = 1'b1;
          w_sdat_nxt  = pick_bit(MSBF,
                          data_in[WIDTH-1],
                          data_in[0]);
        end
      end
      (r_state == SHIFT): begin
        w_sen_nxt  = 1'b1;
        w_sdat_nxt = r_sdat;
        if (w_tick) begin
          if (r_bit == LBIT) begin
            w_state_nxt = LOAD;
            w_sen_nxt   = 1'b0;
            w_ldn_nxt   = 1'b0;
          end else begin
            w_bit_nxt  = r_bit + 1'b1;
            w_sh_nxt   = w_sh_adv;
            w_sdat_nxt = pick_bit(MSBF,
                           w_sh_adv[WIDTH-1],
                           w_sh_adv[0]);
          end
        end else begin
          w_sclk_nxt = w_half || (w_phase == MID);
        end
      end
      (r_state == LOAD): begin
        w_sdat_nxt = r_sdat;
        if (w_tick) begin
          w_state_nxt = IDLE;
          w_sdat_nxt  = 1'b0;
        end else begin
          w_ldn_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_bit   <= '0;
      r_sclk  <= 1'b0;
      r_sen   <= 1'b0;
      r_sdat  <= 1'b0;
      r_ldn   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_sh    <= w_sh_nxt;
      r_bit   <= w_bit_nxt;
      r_sclk  <= w_sclk_nxt;
      r_sen   <= w_sen_nxt;
      r_sdat  <= w_sdat_nxt;
      r_ldn   <= w_ldn_nxt;
    end
  end

  assign ready_out     = (r_state == IDLE);
  assign busy_out      = (r_state != IDLE);
  assign scan_clk_out  = r_sclk;
  assign scan_en_out   = r_sen;
  assign scan_data_out = r_sdat;
  assign load_n_out    = r_ldn;

endmodule
